// File: rtl/ntru_encrypt_mac.sv
// NTRU encrypt engine: c = r*h + m over Z_q[x]/(x^N - 1), q = 2^Q_WIDTH.
// Serial load, N-step parallel ternary MAC over rotating h, serial unload.
module ntru_encrypt_mac #(
    parameter int N       = 701,
    parameter int Q_WIDTH = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Q_WIDTH-1:0] in_h,
    input  logic [1:0]         in_r,
    input  logic [1:0]         in_m,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Q_WIDTH-1:0] out_c,
    output logic               out_last,
    output logic               busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        OUTPUT
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic [Q_WIDTH-1:0] h_q   [N];
    logic [1:0]        r_q   [N];
    logic [Q_WIDTH-1:0] acc_q [N];

    logic               in_fire, out_fire;
    logic               nz_j, neg_j;
    logic [Q_WIDTH-1:0] m_lift;
    logic [Q_WIDTH-1:0] neg_ext;

    assign in_fire  = in_valid && (state_q == LOAD);
    assign out_fire = out_ready && (state_q == OUTPUT);
    assign nz_j     = r_q[cnt_q][1];
    assign neg_j    = r_q[cnt_q][0];
    assign neg_ext  = {Q_WIDTH{neg_j}};

    // Ternary m lifted into Z_q: +1 -> 1, -1 -> q-1, anything without nz -> 0.
    always_comb begin
        m_lift = '0;
        if (in_m[1]) begin
            m_lift = in_m[0] ? '1 : Q_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    if (cnt_q == LAST) begin
                        state_d = COMPUTE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            COMPUTE: begin
                if (cnt_q == LAST) begin
                    state_d = OUTPUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            OUTPUT: begin
                if (out_fire) begin
                    if (cnt_q == LAST) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == LOAD);
        out_valid = (state_q == OUTPUT);
        busy      = (state_q == COMPUTE) || (state_q == OUTPUT);
        out_last  = (state_q == OUTPUT) && (cnt_q == LAST);
        out_c     = acc_q[cnt_q];
    end

    // h is loaded straight into the rotating register; step j sees h[(k-j) mod N].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                h_q[k]   <= '0;
                r_q[k]   <= '0;
                acc_q[k] <= '0;
            end
        end else if (state_q == LOAD) begin
            if (in_fire) begin
                h_q[cnt_q]   <= in_h;
                r_q[cnt_q]   <= in_r;
                acc_q[cnt_q] <= m_lift;
            end
        end else if (state_q == COMPUTE) begin
            for (int k = 0; k < N; k++) begin
                h_q[k] <= h_q[(k + N - 1) % N];
                if (nz_j) begin
                    acc_q[k] <= acc_q[k] + (h_q[k] ^ neg_ext)
                                + {{(Q_WIDTH-1){1'b0}}, neg_j};
                end
            end
        end
    end

endmodule

// File: doc/ntru_encrypt_mac.md
Name: ntru_encrypt_mac

Overview:
- Sequential encryption-side polynomial engine: computes c = r*h + m in Z_q[x]/(x^N - 1), with q = 2^Q_WIDTH.
- Inputs: h is the public key with Q_WIDTH-bit coefficients; r and m are ternary.
- It is the transmit-side counterpart of the decrypt-side ternary multiply-accumulate lane. It uses the same per-lane rule: a nonzero ternary coefficient adds h or its two's-complement negation to the accumulator lane.
- Coefficients stream in serially, N parallel lanes accumulate over N cycles, and c streams out serially.

Parameters:
- N, 701, polynomial length (number of coefficients).
- Q_WIDTH, 13, coefficient width; all arithmetic is mod 2^Q_WIDTH by natural wrap.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input coefficient triple valid.
- in_ready  output  1  block accepts a triple this cycle.
- in_h  input  Q_WIDTH  coefficient h_i.
- in_r  input  2  ternary r_i as {nz, neg}.
- in_m  input  2  ternary m_i as {nz, neg}.
- out_valid  output  1  out_c valid.
- out_ready  input  1  downstream accepts out_c.
- out_c  output  Q_WIDTH  ciphertext coefficient c_k.
- out_last  output  1  high with c_{N-1}.
- busy  output  1  high in COMPUTE and OUTPUT.

Behaviour:
- **Reset:** clk rising edge with rst_n=0 forces state LOAD and clears all counters, h/r/accumulator arrays and out_c. Outputs: in_ready=1, out_valid=0, out_last=0, busy=0. Reset mid-operation aborts immediately; no partial output follows.
- **Ternary encoding:**
  - 2'b00 = 0, 2'b10 = +1, 2'b11 = -1.
  - 2'b01 = 0; nz gates and neg is ignored.
- **State LOAD:**
  - in_ready=1. Handshake fires when in_valid && in_ready.
  - Triple i (i = 0..N-1, in order) writes h_reg[i]=in_h and r_reg[i]=in_r.
  - It also initialises acc[i] = lift(in_m): 0 → 0, +1 → 1, -1 → 2^Q_WIDTH-1.
  - The counter increments on each handshake. After the N-th handshake the next state is COMPUTE and in_ready drops in the following cycle.
- **State COMPUTE:** exactly N cycles, step j = 0..N-1, in_ready=0, out_valid=0.
  - **Update:** for every lane k in parallel, if r_reg[j].nz then acc[k] <= acc[k] + (h_rot[k] XOR {Q_WIDTH{neg}}) + neg, mod 2^Q_WIDTH; otherwise acc[k] is unchanged.
  - **Rotation:** h_rot rotates every step whether or not r_reg[j] is zero: h_rot[k] <= h_rot[k-1], h_rot[0] <= h_rot[N-1]. Rotation starts from h_rot = h_reg, so at step j, h_rot[k] = h[(k-j) mod N].
  - **Exit:** after step N-1 the next state is OUTPUT.
- **State OUTPUT:**
  - out_valid=1 and out_c = acc[idx], with idx from 0.
  - On out_valid && out_ready, idx increments.
  - out_last=1 when idx = N-1.
  - While out_ready=0, out_c/out_last hold stable.
  - After the handshake with out_last, the next state is LOAD: out_valid=0 and in_ready=1 the next cycle.
- **Latency:** last input handshake → first out_valid = N+1 cycles.
- **Throughput:** one coefficient per cycle in LOAD and OUTPUT with no bubbles while valid/ready are held high.
- **busy:** busy=1 exactly in COMPUTE and OUTPUT.
- **Input ignored:** in_valid outside LOAD has no effect.

Test Plan:
- **Identity** (N=5, Q_WIDTH=13): h=[1,2,3,4,5], r=[+1,0,0,0,0], m=0 → c=[1,2,3,4,5]; out_last only on the 5th beat; first out_valid 6 cycles after the last input.
- **Rotation:** same h, r=[0,+1,0,0,0], m=0 → c=[5,1,2,3,4].
- **Negation and m-lift:**
  - h=[1,2,3,4,5], r=[-1,0,0,0,0], m=0 → c=[8191,8190,8189,8188,8187].
  - h=anything, r=0, m=[+1,-1,0,0,0] → c=[1,8191,0,0,0].
  - r_i=2'b01 behaves as 0.
- **Wrap-around:** all h=8191, all r=+1, m=0 → every c_k = 5*8191 mod 8192 = 8187.
- **Backpressure:** out_ready toggled 1,0,0,1,... during OUTPUT → out_c and out_last stable while stalled; all 5 values delivered in order; then in_ready=1 for the next frame, and a back-to-back second frame computes correctly.
- **Reset mid-operation:** assert rst_n=0 for one cycle during COMPUTE step 2 → next cycle in_ready=1, out_valid=0, busy=0. A fresh identity frame then yields [1,2,3,4,5] with no residue from the aborted frame.
